// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state encoding and countdown width.
package mdu_pkg;

  localparam int unsigned MDU_CNT_W           = 4;
  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: maps op/operands to the 64-bit {hi,lo} result,
// including the divide-by-zero result {src_a, 0xFFFFFFFF}.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    prod_u = {32'b0, a_i} * {32'b0, b_i};
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    is_signed = (op_i == MDU_DIV);
    a_neg     = is_signed & a_i[31];
    b_neg     = is_signed & b_i[31];
    a_mag     = a_neg ? (32'd0 - a_i) : a_i;
    b_mag     = b_neg ? (32'd0 - b_i) : b_i;
    q_mag     = (b_mag == '0) ? '0 : (a_mag / b_mag);
    r_mag     = (b_mag == '0) ? '0 : (a_mag % b_mag);
    quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem       = a_neg ? (32'd0 - r_mag) : r_mag;

    case (op_i)
      MDU_MULT:  res_o = prod_s;
      MDU_MULTU: res_o = prod_u;
      default: begin
        if (b_i == '0) res_o = {a_i, 32'hFFFF_FFFF};
        else           res_o = {rem, quot};
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div controller: countdown FSM, HI/LO registers and D-stage stall.
// Optional MDU_DIV0_KEEP_EN: divide by zero runs full latency but leaves HI/LO unchanged.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        cancel,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  localparam logic [MDU_CNT_W-1:0] MULT_LD = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_LD  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE = MDU_CNT_W'(1);

  mdu_state_e           state_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic [63:0]          pend_q;
  logic                 pend_ok_q;
  logic [31:0]          hi_q;
  logic [31:0]          lo_q;
  logic                 busy_q;

  logic [63:0]          core_res;
  logic                 commit_ok_d;
  logic                 accept;

  mdu_core u_core (
    .op_i  (op),
    .a_i   (src_a),
    .b_i   (src_b),
    .res_o (core_res)
  );

  always_comb begin
    accept = start & ~cancel;
`ifdef MDU_DIV0_KEEP_EN
    commit_ok_d = !(mdu_is_div(op) && (src_b == '0));
`else
    commit_ok_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            pend_q    <= core_res;
            pend_ok_q <= commit_ok_d;
            cnt_q     <= mdu_is_div(op) ? DIV_LD : MULT_LD;
            busy_q    <= 1'b1;
            state_q   <= MDU_RUN;
          end else if (!cancel) begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        MDU_RUN: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (pend_ok_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign stall_req = md_use_d & (busy_q | accept);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops against
// a longint arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        cancel;
  logic        md_use_d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .cancel    (cancel),
    .md_use_d  (md_use_d),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ph,
                                             input logic [31:0] pl);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     r, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = {ph, pl};
    if (o[1] && b == 32'd0) begin
`ifdef MDU_DIV0_KEEP_EN
      r = {ph, pl};
`else
      r = {a, 32'hFFFF_FFFF};
`endif
    end else begin
      case (o)
        2'd0: r = sa * sb;
        2'd1: r = ua * ub;
        2'd2: begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = sq;
          r64 = sr;
          r = {r64[31:0], q64[31:0]};
        end
        default: begin
          q64 = ua / ub;
          r64 = ua % ub;
          r = {r64[31:0], q64[31:0]};
        end
      endcase
    end
    return r;
  endfunction

  // Issues one op at the current negedge; returns at the negedge after busy drops.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    start = 1'b1; op = o; src_a = a; src_b = b;
    {m_hi, m_lo} = ref_result(o, a, b, m_hi, m_lo);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; wdata = h;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = l;
    @(negedge clk);
    mtlo = 1'b0;
    m_hi = h; m_lo = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; cancel = 1'b0; md_use_d = 1'b1;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    m_hi = '0; m_lo = '0;
    md_use_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int cyc;
    do_op(2'd0, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (cyc != MC) begin failures++; $display("FAIL mult_latency got=%0d exp=%0d", cyc, MC); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
    do_op(2'd1, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (hi !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_div();
    int cyc;
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc != DC) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", cyc, DC); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    do_op(2'd3, 32'd7, 32'd2, cyc);
    checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_lo got=%h exp=3", lo); end
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_hi got=%h exp=1", hi); end
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_random();
    int cyc;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a & 32'h8000_00FF;
      do_op(o, a, b, cyc);
      checks++; if (cyc != (o[1] ? DC : MC)) begin failures++; $display("FAIL rand_latency i=%0d op=%0d got=%0d exp=%0d", i, o, cyc, o[1] ? DC : MC); end
      checks++; if (hi !== m_hi) begin failures++; $display("FAIL rand_hi i=%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, hi, m_hi); end
      checks++; if (lo !== m_lo) begin failures++; $display("FAIL rand_lo i=%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, lo, m_lo); end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int cyc;
    md_use_d = 1'b1;
    start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
    {m_hi, m_lo} = ref_result(2'd3, 32'd100, 32'd7, m_hi, m_lo);
    #1;
    checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL stall_start got=%0b exp=1", stall_req); end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL stall_busy cyc=%0d got=%0b exp=1", cyc, stall_req); end
      @(negedge clk);
    end
    checks++; if (cyc != DC) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", cyc, DC); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", stall_req); end
    checks++; if (lo !== m_lo) begin failures++; $display("FAIL stall_lo got=%h exp=%h", lo, m_lo); end
    md_use_d = 1'b0;
  endtask

  task automatic test_cancel();
    write_hilo(32'h1234_5678, 32'h1234_5678);
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi got=%h exp=12345678", hi); end
    checks++; if (lo !== 32'h1234_5678) begin failures++; $display("FAIL mtlo got=%h exp=12345678", lo); end
    start = 1'b1; cancel = 1'b1; md_use_d = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd4;
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL cancel_stall got=%0b exp=0", stall_req); end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; md_use_d = 1'b0; mthi = 1'b0;
    for (int i = 0; i < MC + 1; i++) begin
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy cyc=%0d got=%0b exp=0", i, busy); end
      @(negedge clk);
    end
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL cancel_hi got=%h exp=12345678", hi); end
    checks++; if (lo !== 32'h1234_5678) begin failures++; $display("FAIL cancel_lo got=%h exp=12345678", lo); end
  endtask

  task automatic test_cancel_run();
    int cyc;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    start = 1'b1; op = 2'd0; src_a = a; src_b = b;
    {m_hi, m_lo} = ref_result(2'd0, a, b, m_hi, m_lo);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      cancel = (cyc == 2);
      @(negedge clk);
    end
    cancel = 1'b0;
    checks++; if (cyc != MC) begin failures++; $display("FAIL cancel_run_latency got=%0d exp=%0d", cyc, MC); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL cancel_run_commit got=%h%h exp=%h%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid_run();
    write_hilo(32'hCAFE_0001, 32'hCAFE_0002);
    start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL midrst_lo got=%h exp=0", lo); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DC + 2) @(negedge clk);
    checks++; if ({busy, hi, lo} !== 65'd0) begin failures++; $display("FAIL midrst_discard got=%0b/%h/%h exp=0/0/0", busy, hi, lo); end
  endtask

  task automatic test_div0();
    int cyc;
    write_hilo(32'hAAAA_5555, 32'h0F0F_0F0F);
    do_op(2'd2, 32'd5, 32'd0, cyc);
    checks++; if (cyc != DC) begin failures++; $display("FAIL div0_latency got=%0d exp=%0d", cyc, DC); end
`ifdef MDU_DIV0_KEEP_EN
    checks++; if (hi !== 32'hAAAA_5555) begin failures++; $display("FAIL div0_hi got=%h exp=aaaa5555", hi); end
    checks++; if (lo !== 32'h0F0F_0F0F) begin failures++; $display("FAIL div0_lo got=%h exp=0f0f0f0f", lo); end
`else
    checks++; if (hi !== 32'd5) begin failures++; $display("FAIL div0_hi got=%h exp=5", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
`endif
    do_op(2'd3, 32'h9000_0001, 32'd0, cyc);
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL divu0 got=%h%h exp=%h%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_op(2'd1, 32'd123456, 32'd789, cyc);
    checks++; if (lo !== 32'd97406784) begin failures++; $display("FAIL b2b_first got=%h exp=%h", lo, 32'd97406784); end
    do_op(2'd2, 32'hFFFF_FF9C, 32'd7, cyc);
    checks++; if (cyc != DC) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, DC); end
    checks++; if (lo !== 32'hFFFF_FFF2) begin failures++; $display("FAIL b2b_lo got=%h exp=fffffff2", lo); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL b2b_hi got=%h exp=fffffffe", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_cancel();
    @(negedge clk);
    test_cancel_run();
    test_back_to_back();
    test_div0();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the five-stage pipeline. It accepts a mult/div issued in E, computes the 64-bit result, models the fixed execution latency with a countdown, commits HI/LO at completion, and raises the stall request that holds D-stage HI/LO instructions while the unit is occupied. Its `stall_req` is ORed into the pipeline stall signal that freezes PC and the D register and bubbles E.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (range 1-15).
- `DIV_CYCLES`, 10: busy cycles for div/divu (range 1-15).

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  E-stage mult/multu/div/divu is valid this cycle.
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with `start`.
- `src_a`, `src_b`  in  32 each  E-stage rs/rt values.
- `mthi`, `mtlo`  in  1 each  E-stage mthi/mtlo valid.
- `wdata`  in  32  mthi/mtlo data (rs).
- `cancel`  in  1  exception/interrupt taken this cycle; kills E-stage `start`/`mthi`/`mtlo`.
- `md_use_d`  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `hi`, `lo`  out  32 each  registered HI/LO; mfhi/mflo read these.
- `busy`  out  1  operation in flight (registered).
- `stall_req`  out  1  combinational: `md_use_d & (busy | (start & ~cancel))`.

## Operation
- States: IDLE, RUN. Reset: IDLE, `hi`=`lo`=0, `busy`=0, counter 0, operand/result registers 0.
- IDLE, `start & ~cancel`: latch the 64-bit result of `op` on `src_a`/`src_b` into a pending register, load the counter with `MULT_CYCLES` or `DIV_CYCLES`, go to RUN, and set `busy`=1.
- RUN: decrement each cycle. On the edge where counter==1, write pending to {`hi`,`lo`}, clear `busy`, and go to IDLE.
- mult: signed 32x32 into 64 bits. multu: unsigned. `hi`=upper word, `lo`=lower word.
- div: `lo`=signed quotient truncated toward zero, `hi`=remainder with the dividend's sign. divu: unsigned. 0x80000000/-1 gives `lo`=0x80000000, `hi`=0.
- `mthi`/`mtlo` in IDLE without `cancel`: write `wdata` to that register at the edge. No latency, no `busy`.
- Ignored events: `start`/`mthi`/`mtlo` while RUN (this cannot occur, because `stall_req` holds them in D). `start` with `mthi` in the same cycle: `start` wins.
- `cancel` affects only the current E-stage inputs. An operation already in RUN completes and commits, because its instruction retired before the exception.
- `rst_n` low mid-RUN: immediately return to the reset values. The pending result is discarded.

## Timing
- `start` sampled at edge T. `busy` is high over cycles T+1 through T+N, where N is the latency. `hi`/`lo` hold new values from cycle T+N+1, and `busy` is low in the same cycle.
- A D-stage HI/LO instruction co-resident with `start` in E stalls from that cycle. It may advance in cycle T+N+1 and reads committed values.
- Back-to-back: a second `start` can be accepted in cycle T+N+1.

## Configuration
- `MDU_DIV0_KEEP_EN` defined: div/divu with `src_b`==0 still occupies the full `DIV_CYCLES`, but the commit is suppressed, so `hi`/`lo` are unchanged.
- Not defined: a divide by zero commits `hi`=`src_a` and `lo`=0xFFFFFFFF for both div and divu.

## Structure
- `mdu_pkg` holds:
  - the op encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the default latencies;
  - the state encoding: `MDU_IDLE`, `MDU_RUN`;
  - the counter width: 4.
- Sub-module `mdu_core` is purely combinational. It maps `op`/`src_a`/`src_b` to a 64-bit {hi,lo}, including the divide-by-zero rule. `mdu_ctrl` owns the FSM, counter, registers and stall logic.

## Test plan
- Reset, then mult with 0xFFFFFFFF × 2:
  - `busy` is high for exactly 5 cycles;
  - `hi`/`lo` are then 0xFFFFFFFF/0xFFFFFFFE;
  - multu with the same operands gives 0x00000001/0xFFFFFFFE.
- div with -7 / 2 gives `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF after 10 busy cycles; divu with 7 / 2 gives `lo`=3 and `hi`=1.
- Hold `md_use_d`=1 (mflo in D) while `start` is issued: `stall_req` is high from the `start` cycle through the last busy cycle, then drops; `lo` is already updated.
- `start` with `cancel`=1: no state change, `busy` stays 0, `hi`/`lo` keep 0x12345678 previously written via `mthi`/`mtlo`.
- `cancel` pulse during RUN: the operation still commits at cycle N; deasserting `rst_n` mid-RUN clears `busy`, `hi` and `lo` to 0 without waiting for a clock edge.
- div of 5 / 0:
  - with `MDU_DIV0_KEEP_EN`, `hi`/`lo` are unchanged after 10 cycles;
  - without it, `hi`=5 and `lo`=0xFFFFFFFF.
